// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO read-side burst controller.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  localparam int unsigned SKID_DEPTH = 3;

endpackage

// File: rtl/fifo_reader_skid.sv
// Three-entry register skid buffer that absorbs FIFO words while the consumer stalls.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem_q [SKID_DEPTH];
  logic [DATA_W-1:0] mem_d [SKID_DEPTH];
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_reader.sv
// Drains a fixed-length burst from a synchronous FIFO onto a valid/ready stream;
// the read strobe never depends on out_ready, the skid buffer covers the read latency.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned LEN_W     = $clog2(BURST_MAX + 1)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              EN,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              fifo_rd,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   req_left_q, req_left_d;
  logic [LEN_W-1:0]   rx_left_q, rx_left_d;
  logic               inflight_q, inflight_d;
  logic               done_q, done_d;

  logic [1:0]         occ;
  logic [2:0]         occ_sum;
  logic [LEN_W-1:0]   len_clamped;
  logic               hs;
  logic               last_hs;

  fifo_reader_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .push     (inflight_q),
    .push_data(fifo_data),
    .pop      (hs),
    .occ      (occ),
    .head_data(out_data)
  );

  assign occ_sum     = {1'b0, occ} + {2'b00, inflight_q};
  assign len_clamped = (burst_len > LEN_W'(BURST_MAX)) ? LEN_W'(BURST_MAX) : burst_len;

  assign fifo_rd = EN && (state_q == FETCH) && !fifo_empty && (req_left_q != '0)
                   && (occ_sum < 3'(SKID_DEPTH));

  assign out_valid = (occ != 2'd0);
  assign hs        = out_valid && out_ready;
  assign last_hs   = hs && (rx_left_q == LEN_W'(1));
  assign out_last  = out_valid && (rx_left_q == LEN_W'(1));
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  always_comb begin
    state_d    = state_q;
    req_left_d = req_left_q;
    rx_left_d  = rx_left_q;
    inflight_d = fifo_rd;
    done_d     = 1'b0;
    if (fifo_rd) req_left_d = req_left_q - LEN_W'(1);
    if (hs)      rx_left_d  = rx_left_q - LEN_W'(1);
    case (state_q)
      IDLE: begin
        if (EN && start && (burst_len != '0)) begin
          state_d    = FETCH;
          req_left_d = len_clamped;
          rx_left_d  = len_clamped;
        end
      end
      FETCH: begin
        if (EN && (req_left_q == '0)) state_d = DRAIN;
      end
      DRAIN:   state_d = state_q;
      default: state_d = IDLE;
    endcase
    // The stream side runs even with EN low, so the final handshake may land in
    // FETCH if EN dropped after the last read; exit from either busy state.
    if ((state_q != IDLE) && last_hs) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= IDLE;
      req_left_q <= '0;
      rx_left_q  <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_left_q <= req_left_d;
      rx_left_q  <= rx_left_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
    end
  end

  a_no_overflow: assert property (@(posedge Clk) disable iff (!Rst_n)
    occ_sum <= 3'(SKID_DEPTH));

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: FIFO model, count-based reference model and directed scenarios.
module tb_fifo_reader;
  localparam int DW   = 32;
  localparam int BMAX = 16;
  localparam int LW   = 5;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          EN = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          busy, done, fifo_rd;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;

  fifo_reader #(.DATA_W(DW), .BURST_MAX(BMAX), .LEN_W(LW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .EN(EN), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .fifo_rd(fifo_rd), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: registered read data, one cycle after the strobe.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic          rd_s = 1'b0;
  logic [DW-1:0] fifo_w;

  always @(posedge Clk) begin
    if (rd_s) begin
      if (fq.size() > 0) begin
        fifo_w = fq.pop_front();
        exp_q.push_back(fifo_w);
        fifo_data <= fifo_w;
      end else begin
        fifo_data <= 32'hDEAD_BEEF;
      end
    end
  end

  // Reference model: counts of reads issued and words accepted per burst.
  bit m_busy = 0;
  int m_len = 0, m_reads = 0, m_hs = 0;
  bit m_rd_prev = 0, m_done_next = 0;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data = '0;
  int rd_total = 0, hs_total = 0, done_total = 0;

  always @(negedge Clk) begin : mon
    int outst;
    bit exp_rd, exp_valid, exp_last, hs;
    rd_s = fifo_rd;
    if (!Rst_n) begin
      m_busy = 0; m_len = 0; m_reads = 0; m_hs = 0;
      m_rd_prev = 0; m_done_next = 0; prev_stall = 0;
      exp_q.delete();
    end else begin
      outst     = m_reads - m_hs;
      exp_rd    = m_busy && EN && !fifo_empty && (m_reads < m_len) && (outst < 3);
      exp_valid = (m_reads - int'(m_rd_prev) - m_hs) > 0;
      exp_last  = exp_valid && (m_hs == m_len - 1);
      chk("fifo_rd", fifo_rd, exp_rd);
      chk("out_valid", out_valid, exp_valid);
      chk("out_last", out_last, exp_last);
      chk("done", done, m_done_next);
      chk("busy", busy, m_busy);
      if (prev_stall) chk("hold_data", out_data, prev_data);
      hs = out_valid && out_ready;
      if (hs) begin
        if (exp_q.size() == 0) chk("word_available", 0, 1);
        else chk("out_data", out_data, exp_q.pop_front());
      end
      prev_stall  = out_valid && !out_ready;
      prev_data   = out_data;
      m_done_next = hs && m_busy && (m_hs == m_len - 1);
      if (hs) begin m_hs++; hs_total++; end
      if (fifo_rd) begin m_reads++; rd_total++; end
      m_rd_prev = fifo_rd;
      if (done) done_total++;
      if (m_done_next) m_busy = 0;
      else if (!m_busy && EN && start && burst_len != '0) begin
        m_busy  = 1;
        m_len   = (int'(burst_len) > BMAX) ? BMAX : int'(burst_len);
        m_reads = 0;
        m_hs    = 0;
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic start_burst(input int len);
    tick();
    start = 1'b1;
    burst_len = LW'(len);
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fifo_rd"}, fifo_rd, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    tick();
    Rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    @(negedge Clk);
    while (busy && n < maxc) begin
      @(negedge Clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
    tick();
    tick();
  endtask

  int r0, h0, d0;

  initial begin
    // Reset values
    tick();
    tick();
    check_reset_outputs("reset");
    Rst_n = 1'b1;
    EN = 1'b1;
    out_ready = 1'b1;

    // Nominal 4-word burst with exact cycle timing
    for (int i = 0; i < 4; i++) push_word(32'h10 + DW'(i));
    start_burst(4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      chk("t_rd", fifo_rd, (c <= 4));
      chk("t_valid", out_valid, (c >= 3 && c <= 6));
      chk("t_last", out_last, (c == 6));
      chk("t_done", done, (c == 7));
      if (c >= 3 && c <= 6) chk("t_data", out_data, 32'h10 + DW'(c - 3));
    end
    tick();

    // Reset during FETCH with two words buffered, then a fresh 2-word burst
    for (int i = 0; i < 8; i++) push_word(32'h200 + DW'(i));
    out_ready = 1'b0;
    start_burst(8);
    tick();
    tick();
    do_reset();
    chk("rst_fifo_popped", fq.size(), 5);
    out_ready = 1'b1;
    h0 = hs_total; d0 = done_total;
    start_burst(2);
    wait_idle(50);
    chk("rst_burst_hs", hs_total - h0, 2);
    chk("rst_burst_done", done_total - d0, 1);
    fq.delete();
    tick();

    // Consumer stall: reads stop at three outstanding words
    for (int i = 0; i < 8; i++) push_word(32'h300 + DW'(i));
    out_ready = 1'b0;
    r0 = rd_total; h0 = hs_total; d0 = done_total;
    start_burst(8);
    repeat (9) @(negedge Clk);
    #1;
    chk("stall_rd_count", rd_total - r0, 3);
    chk("stall_valid", out_valid, 1);
    tick();
    out_ready = 1'b1;
    wait_idle(60);
    chk("stall_hs", hs_total - h0, 8);
    chk("stall_rd_total", rd_total - r0, 8);
    chk("stall_done", done_total - d0, 1);

    // Sparse FIFO: one word every 4 cycles
    r0 = rd_total; d0 = done_total;
    start_burst(3);
    for (int i = 0; i < 3; i++) begin
      repeat (3) tick();
      push_word(32'h400 + DW'(i));
      tick();
    end
    wait_idle(40);
    chk("sparse_rd", rd_total - r0, 3);
    chk("sparse_done", done_total - d0, 1);

    // EN low for five cycles mid-burst
    for (int i = 0; i < 6; i++) push_word(32'h500 + DW'(i));
    out_ready = 1'b0;
    h0 = hs_total; d0 = done_total;
    start_burst(6);
    tick();
    EN = 1'b0;
    r0 = rd_total;
    repeat (5) tick();
    chk("en_off_rd", rd_total - r0, 0);
    chk("en_off_valid", out_valid, 1);
    chk("en_off_busy", busy, 1);
    EN = 1'b1;
    out_ready = 1'b1;
    wait_idle(60);
    chk("en_burst_hs", hs_total - h0, 6);
    chk("en_burst_done", done_total - d0, 1);

    // Zero length and start while busy
    for (int i = 0; i < 4; i++) push_word(32'h600 + DW'(i));
    r0 = rd_total; d0 = done_total; h0 = hs_total;
    start_burst(0);
    repeat (5) tick();
    chk("zero_rd", rd_total - r0, 0);
    chk("zero_done", done_total - d0, 0);
    chk("zero_busy", busy, 0);
    start_burst(3);
    start_burst(5);
    wait_idle(40);
    chk("busy_start_rd", rd_total - r0, 3);
    chk("busy_start_hs", hs_total - h0, 3);
    chk("busy_start_done", done_total - d0, 1);
    chk("busy_start_left", fq.size(), 1);
    fq.delete();
    tick();

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c == 1500) do_reset();
      EN        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && fq.size() < 40) push_word($urandom());
      start     = ($urandom_range(0, 7) == 0);
      burst_len = LW'($urandom_range(0, 20));
    end
    tick();
    start = 1'b0;
    EN = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && busy; c++) begin
      if (fq.size() == 0) push_word($urandom());
      tick();
    end
    wait_idle(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
